// File: rtl/puerta_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : puerta_pkg
//  Description : Shared definitions for the automatic door motion controller:
//                FSM state codes, move-target encoding and default timing.
//  Revision    : 1.0 - initial release
// ============================================================================
package puerta_pkg;

    // FSM state codes as seen on the state output; code 7 is illegal.
    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_DEAD    = 3'd1,
        ST_OPENING = 3'd2,
        ST_OPEN    = 3'd3,
        ST_CLOSING = 3'd4,
        ST_FAULT   = 3'd5,
        ST_ESTOP   = 3'd6
    } state_t;

    // Direction of the move that follows the dead-time.
    localparam logic TGT_OPEN  = 1'b1;
    localparam logic TGT_CLOSE = 1'b0;

    // Default timing constants (cycles).
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_DEAD_CYCLES   = 8;
    localparam int DEF_HOLD_CYCLES   = 1000;
    localparam int DEF_TRAVEL_CYCLES = 4000;

endpackage
`default_nettype wire

// File: rtl/puerta_sync.sv
`default_nettype none
// ============================================================================
//  Module      : puerta_sync
//  Description : W-bit two-flop synchronizer for asynchronous input pins.
//  Revision    : 1.0 - initial release
//  Ports       : clk  - system clock
//                rst  - asynchronous active-high reset (clears both stages)
//                d_i  - raw asynchronous inputs
//                q_o  - synchronized outputs (two clk edges of latency)
// ============================================================================
module puerta_sync #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/puerta_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : puerta_ctrl
//  Description : Automatic door motion controller. Sequences open/close moves
//                with a motor dead-time before each move, holds the door open
//                for a programmable dwell, reverses on presence while closing,
//                flags travel timeouts and handles emergency stop.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                ena               - low freezes FSM/counter, motors off
//                sen, se, la, lc   - presence, e-stop, open/closed limits
//                ack_fault         - fault clear
//                ma, mc            - motor open / close drive
//                state             - current FSM state code
//                fault, busy       - in FAULT / in DEAD, OPENING or CLOSING
// ============================================================================
module puerta_ctrl
    import puerta_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int DEAD_CYCLES   = DEF_DEAD_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       sen,
    input  logic       se,
    input  logic       la,
    input  logic       lc,
    input  logic       ack_fault,
    output logic       ma,
    output logic       mc,
    output logic [2:0] state,
    output logic       fault,
    output logic       busy
);

    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);

    // Synchronized inputs
    logic [4:0] sync_s;
    logic       sen_s;
    logic       se_s;
    logic       la_s;
    logic       lc_s;
    logic       ack_fault_s;

    puerta_sync #(.W(5)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({ack_fault, lc, la, se, sen}),
        .q_o (sync_s)
    );

    assign {ack_fault_s, lc_s, la_s, se_s, sen_s} = sync_s;

    // FSM / counter state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_q, tgt_d;
    logic             cnt_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLOSED;
            cnt_q   <= '0;
            tgt_q   <= TGT_CLOSE;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_clr = 1'b0;

        if (se_s) begin
            state_d = ST_ESTOP;
        end else if (la_s && lc_s && (state_q != ST_ESTOP) && (state_q != ST_FAULT)) begin
            // Both limits at once means a broken switch or wiring.
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_CLOSED: begin
                    if (sen_s) begin
                        state_d = ST_DEAD;
                        tgt_d   = TGT_OPEN;
                    end else if (!lc_s) begin
                        state_d = ST_DEAD;
                        tgt_d   = TGT_CLOSE;
                    end
                end
                ST_DEAD: begin
                    if (cnt_q == DEAD_LAST) begin
                        state_d = (tgt_q == TGT_OPEN) ? ST_OPENING : ST_CLOSING;
                    end
                end
                ST_OPENING: begin
                    if (la_s) begin
                        state_d = ST_OPEN;
                    end else if (cnt_q == TRAVEL_LAST) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_OPEN: begin
                    // Losing the open limit re-drives open before anything else.
                    if (!la_s) begin
                        state_d = ST_DEAD;
                        tgt_d   = TGT_OPEN;
                    end else if (sen_s) begin
                        cnt_clr = 1'b1;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ST_DEAD;
                        tgt_d   = TGT_CLOSE;
                    end
                end
                ST_CLOSING: begin
                    if (lc_s) begin
                        state_d = ST_CLOSED;
                    end else if (sen_s) begin
                        state_d = ST_DEAD;
                        tgt_d   = TGT_OPEN;
                    end else if (cnt_q == TRAVEL_LAST) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    if (ack_fault_s) begin
                        state_d = ST_CLOSED;
                    end
                end
                ST_ESTOP: begin
                    state_d = ST_CLOSED;
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    // Shared counter: cleared on every state change, saturating otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Decoded from registered state so open and close drive are exclusive.
    assign ma    = ena & (state_q == ST_OPENING);
    assign mc    = ena & (state_q == ST_CLOSING);
    assign state = state_q;
    assign fault = (state_q == ST_FAULT);
    assign busy  = (state_q == ST_DEAD) || (state_q == ST_OPENING) || (state_q == ST_CLOSING);

endmodule
`default_nettype wire

// File: tb/tb_puerta_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_puerta_ctrl
//  Description : Self-checking bench for puerta_ctrl with DEAD=4, HOLD=10,
//                TRAVEL=20. Table rows drive all inputs on a falling edge,
//                wait n rising edges and compare outputs 1 time unit later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_puerta_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena, sen, se, la, lc, ack_fault;
    logic       ma, mc, fault, busy;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    puerta_ctrl #(
        .CNT_W         (16),
        .DEAD_CYCLES   (4),
        .HOLD_CYCLES   (10),
        .TRAVEL_CYCLES (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .sen       (sen),
        .se        (se),
        .la        (la),
        .lc        (lc),
        .ack_fault (ack_fault),
        .ma        (ma),
        .mc        (mc),
        .state     (state),
        .fault     (fault),
        .busy      (busy)
    );

    // in  = {ena, sen, se, la, lc, ack_fault}
    // out = {ma, mc, fault, busy}
    typedef struct {
        logic [5:0] in;
        int         n;
        logic [2:0] st;
        logic [3:0] out;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [5:0] in, input int n, input logic [2:0] st, input logic [3:0] out);
        vec_t v;
        v.in  = in;
        v.n   = n;
        v.st  = st;
        v.out = out;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [6:0] got, input logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got {state,ma,mc,fault,busy}=%b, expected %b", name, idx, got, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {state, ma, mc, fault, busy};
    endfunction

    initial begin
        bit found;

        // Full cycle
        add(6'b110010,  1, 3'd0, 4'b0000);
        add(6'b100010,  1, 3'd0, 4'b0000);
        add(6'b100010,  1, 3'd1, 4'b0001);
        add(6'b100010,  3, 3'd1, 4'b0001);
        add(6'b100010,  1, 3'd2, 4'b1001);
        add(6'b100100,  2, 3'd2, 4'b1001);
        add(6'b100100,  1, 3'd3, 4'b0000);
        add(6'b100100,  9, 3'd3, 4'b0000);
        add(6'b100000,  1, 3'd1, 4'b0001);
        add(6'b100000,  3, 3'd1, 4'b0001);
        add(6'b100000,  1, 3'd4, 4'b0101);
        add(6'b100010,  2, 3'd4, 4'b0101);
        add(6'b100010,  1, 3'd0, 4'b0000);
        // Hold extension
        add(6'b110010,  3, 3'd1, 4'b0001);
        add(6'b110010,  3, 3'd1, 4'b0001);
        add(6'b110100,  1, 3'd2, 4'b1001);
        add(6'b110100,  3, 3'd3, 4'b0000);
        add(6'b110100, 30, 3'd3, 4'b0000);
        add(6'b100100, 11, 3'd3, 4'b0000);
        add(6'b100000,  1, 3'd1, 4'b0001);
        add(6'b100000,  3, 3'd1, 4'b0001);
        add(6'b100000,  1, 3'd4, 4'b0101);
        // Reversal
        add(6'b100000,  3, 3'd4, 4'b0101);
        add(6'b110000,  2, 3'd4, 4'b0101);
        add(6'b100000,  1, 3'd1, 4'b0001);
        add(6'b100000,  3, 3'd1, 4'b0001);
        add(6'b100000,  1, 3'd2, 4'b1001);
        // Travel timeout and fault clear
        add(6'b100000, 19, 3'd2, 4'b1001);
        add(6'b100000,  1, 3'd5, 4'b0010);
        add(6'b100011,  2, 3'd5, 4'b0010);
        add(6'b100010,  1, 3'd0, 4'b0000);
        add(6'b100010,  2, 3'd0, 4'b0000);
        // E-stop during OPENING
        add(6'b110010,  1, 3'd0, 4'b0000);
        add(6'b100010,  2, 3'd1, 4'b0001);
        add(6'b100000,  4, 3'd2, 4'b1001);
        add(6'b101000,  2, 3'd2, 4'b1001);
        add(6'b101000,  1, 3'd6, 4'b0000);
        add(6'b100010,  2, 3'd6, 4'b0000);
        add(6'b100010,  1, 3'd0, 4'b0000);
        add(6'b100010,  2, 3'd0, 4'b0000);
        // Both limits in CLOSED
        add(6'b100110,  2, 3'd0, 4'b0000);
        add(6'b100110,  1, 3'd5, 4'b0010);
        add(6'b100011,  3, 3'd0, 4'b0000);
        add(6'b100010,  2, 3'd0, 4'b0000);
        // Drift close, freeze with ena=0, resume count to timeout
        add(6'b100000,  3, 3'd1, 4'b0001);
        add(6'b100000,  4, 3'd4, 4'b0101);
        add(6'b100000,  2, 3'd4, 4'b0101);
        add(6'b000000,  1, 3'd4, 4'b0001);
        add(6'b000000, 30, 3'd4, 4'b0001);
        add(6'b100000, 17, 3'd4, 4'b0101);
        add(6'b100000,  1, 3'd5, 4'b0010);
        add(6'b100011,  3, 3'd0, 4'b0000);
        add(6'b100010,  2, 3'd0, 4'b0000);

        // Reset, with ena low until the closed limit has passed the synchronizer
        rst = 1'b1; ena = 1'b0; sen = 1'b0; se = 1'b0; la = 1'b0; lc = 1'b1; ack_fault = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, outs(), 7'b000_0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_ena0", 0, outs(), 7'b000_0000);
        @(negedge clk);
        ena = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ena1", 0, outs(), 7'b000_0000);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            {ena, sen, se, la, lc, ack_fault} = tbl[i].in;
            repeat (tbl[i].n) @(posedge clk);
            #1;
            check("vec", i, outs(), {tbl[i].st, tbl[i].out});
        end

        // Reset asserted mid-OPENING drops the motor without a clock edge
        @(negedge clk);
        sen = 1'b1;
        @(negedge clk);
        sen = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (state == 3'd2) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL reach_opening: state=%0d after 20 cycles, required 2", state);
        end
        check("opening_before_rst", 0, outs(), 7'b010_1001);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", 0, outs(), 7'b000_0000);
        ena = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("after_rst_closed", 0, outs(), 7'b000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
